// File: rtl/spi_pkg.sv
// Shared SPI definitions used by the responder and by the spi0-spi2 master ports.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } spi_state_e;

  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  localparam int unsigned SPI_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser for an asynchronous pin with registered rise/fall strobes.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int unsigned STAGES    = SPI_SYNC_STAGES,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              dly;
  logic [STAGES:0]   vld;

  // vld tracks which flops hold real pin samples rather than reset values, so a
  // pin already at the non-idle level while reset is released never yields a strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain <= {STAGES{RESET_VAL}};
      dly   <= RESET_VAL;
      vld   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      dly   <= chain[STAGES-1];
      vld   <= {vld[STAGES-1:0], 1'b1};
      rise  <= vld[STAGES] & chain[STAGES-1] & ~dly;
      fall  <= vld[STAGES] & ~chain[STAGES-1] & dly;
    end
  end

endmodule

// File: rtl/spi_slave_if.sv
// SPI mode-0 responder, MSB first, with all SPI pins oversampled on wb_clk.
module spi_slave_if
  import spi_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter int unsigned           SYNC_STAGES = SPI_SYNC_STAGES,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_TX  = '1
) (
  input  logic                  wb_clk,
  input  logic                  wb_rst_n,
  input  logic                  spi_sck_i,
  input  logic                  spi_ss_n_i,
  input  logic                  spi_mosi_i,
  output logic                  spi_miso_o,
  output logic                  spi_miso_oe_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  output logic                  tx_underrun_o,
  output logic                  busy_o
);

  localparam int unsigned           CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]      LAST  = CNT_W'(DATA_WIDTH - 1);

  logic sck_rise, sck_fall, ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic mosi_q;

  spi_state_e            state;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  word_done;
  logic [DATA_WIDTH-1:0] tx_sr, rx_sr, hold_data;
  logic                  hold_valid;

  logic                  sample_edge, shift_edge, load_now;
  logic [DATA_WIDTH-1:0] load_word, rx_next;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(SPI_CPOL)) u_sck_sync (
    .clk(wb_clk), .rst_n(wb_rst_n), .d(spi_sck_i), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
    .clk(wb_clk), .rst_n(wb_rst_n), .d(spi_ss_n_i), .rise(ss_rise), .fall(ss_fall)
  );

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) mosi_sync <= '0;
    else           mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
  end

  assign mosi_q     = mosi_sync[SYNC_STAGES-1];
  assign tx_ready_o = ~hold_valid;

  // Select level is tracked through the FSM from the strobes: a frame only starts on a
  // qualified fall and ends on the matching rise, which also covers reset mid-frame.
  always_comb begin
    sample_edge = (SPI_CPOL == SPI_CPHA) ? sck_rise : sck_fall;
    shift_edge  = (SPI_CPOL == SPI_CPHA) ? sck_fall : sck_rise;
    load_word   = hold_valid ? hold_data : DEFAULT_TX;
    rx_next     = {rx_sr[DATA_WIDTH-2:0], mosi_q};
    load_now    = 1'b0;
    if (!ss_rise) begin
      if (state == IDLE)       load_now = ss_fall;
      else if (state == SHIFT) load_now = shift_edge && (bit_cnt == '0) && word_done;
    end
  end

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      word_done     <= 1'b0;
      tx_sr         <= '0;
      rx_sr         <= '0;
      hold_data     <= '0;
      hold_valid    <= 1'b0;
      spi_miso_o    <= 1'b0;
      spi_miso_oe_o <= 1'b0;
      rx_data_o     <= '0;
      rx_valid_o    <= 1'b0;
      tx_underrun_o <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      rx_valid_o    <= 1'b0;
      tx_underrun_o <= 1'b0;

      // A load draws from the register as it stood before this edge, so a word
      // captured on the same edge stays queued for the next load.
      if (load_now && hold_valid) begin
        hold_valid <= 1'b0;
      end else if (tx_valid_i && !hold_valid) begin
        hold_valid <= 1'b1;
        hold_data  <= tx_data_i;
      end

      if (load_now) begin
        tx_sr         <= load_word;
        spi_miso_o    <= load_word[DATA_WIDTH-1];
        tx_underrun_o <= ~hold_valid;
        bit_cnt       <= '0;
      end

      if (ss_rise) begin
        state         <= IDLE;
        spi_miso_oe_o <= 1'b0;
        spi_miso_o    <= 1'b0;
        busy_o        <= 1'b0;
        bit_cnt       <= '0;
        word_done     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (ss_fall) begin
              state         <= LOAD;
              spi_miso_oe_o <= 1'b1;
              busy_o        <= 1'b1;
              word_done     <= 1'b0;
            end
          end
          LOAD: state <= SHIFT;
          SHIFT: begin
            if (sample_edge) begin
              rx_sr <= rx_next;
              if (bit_cnt == LAST) begin
                rx_data_o  <= rx_next;
                rx_valid_o <= 1'b1;
                bit_cnt    <= '0;
                word_done  <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else if (shift_edge && (bit_cnt != '0)) begin
              tx_sr      <= tx_sr << 1;
              spi_miso_o <= tx_sr[DATA_WIDTH-2];
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_if.sv
// Scoreboard bench for spi_slave_if: bit-banged SPI master, queued expectations, monitors.
module tb_spi_slave_if;

  logic       wb_clk = 1'b0;
  logic       wb_rst_n = 1'b0;
  logic       spi_sck_i = 1'b0;
  logic       spi_ss_n_i = 1'b1;
  logic       spi_mosi_i = 1'b0;
  logic       spi_miso_o, spi_miso_oe_o;
  logic [7:0] tx_data_i = 8'h00;
  logic       tx_valid_i = 1'b0;
  logic       tx_ready_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o, tx_underrun_o, busy_o;

  int total = 0;
  int bad = 0;
  int urun_cnt = 0;
  int u0 = 0;
  bit miso_en = 1'b1;

  logic [7:0] exp_rx[$];
  logic [7:0] exp_miso[$];
  logic [7:0] tx_q[$];

  spi_slave_if #(.DATA_WIDTH(8), .SYNC_STAGES(2), .DEFAULT_TX(8'hFF)) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
    .spi_sck_i(spi_sck_i), .spi_ss_n_i(spi_ss_n_i), .spi_mosi_i(spi_mosi_i),
    .spi_miso_o(spi_miso_o), .spi_miso_oe_o(spi_miso_oe_o),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
    .tx_underrun_o(tx_underrun_o), .busy_o(busy_o)
  );

  always #5 wb_clk = ~wb_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // rx / underrun monitor, sampled on the falling wb_clk edge
  always @(negedge wb_clk) begin
    if (tx_underrun_o === 1'b1) urun_cnt++;
    if (rx_valid_o === 1'b1) begin
      if (exp_rx.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rx_extra: got rx_valid with data %0h, expected none", rx_data_o);
      end else begin
        chk("rx_data", 32'(rx_data_o), 32'(exp_rx.pop_front()));
      end
    end
  end

  // miso monitor: the master's view, sampled on each sck rise while selected
  int unsigned nb = 0;
  logic [7:0]  msh = 8'h00;
  logic        oe_ok = 1'b0;
  always @(posedge spi_sck_i or posedge spi_ss_n_i) begin
    if (spi_ss_n_i) begin
      nb = 0;
    end else if (miso_en) begin
      msh   = {msh[6:0], spi_miso_o};
      oe_ok = (nb == 0) ? spi_miso_oe_o : (oe_ok & spi_miso_oe_o);
      nb++;
      if (nb == 8) begin
        nb = 0;
        if (exp_miso.size() == 0) begin
          total++;
          bad++;
          $display("FAIL miso_extra: got byte %0h, expected none", msh);
        end else begin
          chk("miso_byte", 32'({oe_ok, msh}), 32'({1'b1, exp_miso.pop_front()}));
        end
      end
    end
  end

  // sck high and low for 4 wb_clk each; the last fall coincides with ss_n rising
  task automatic spi_frame(input logic [23:0] data, input int unsigned nbits);
    logic [23:0] d;
    d = data;
    @(negedge wb_clk);
    spi_ss_n_i = 1'b0;
    spi_mosi_i = d[23];
    repeat (6) @(negedge wb_clk);
    for (int unsigned i = 0; i < nbits; i++) begin
      spi_sck_i = 1'b1;
      repeat (4) @(negedge wb_clk);
      spi_sck_i = 1'b0;
      d = d << 1;
      spi_mosi_i = d[23];
      if (i == nbits - 1) spi_ss_n_i = 1'b1;
      repeat (4) @(negedge wb_clk);
    end
    repeat (8) @(negedge wb_clk);
  endtask

  task automatic feed_words();
    int unsigned budget;
    budget = 0;
    while (tx_q.size() != 0) begin
      @(negedge wb_clk);
      budget++;
      if (budget > 2000) begin
        total++;
        bad++;
        $display("FAIL tx_feed_timeout: got tx_ready stuck low, expected %0d words accepted", tx_q.size());
        tx_q.delete();
      end else if (tx_ready_o) begin
        tx_data_i  = tx_q.pop_front();
        tx_valid_i = 1'b1;
        @(negedge wb_clk);
        tx_valid_i = 1'b0;
      end
    end
  endtask

  task automatic end_test(input string name, input int exp_urun);
    repeat (4) @(negedge wb_clk);
    chk({name, "_rx_left"}, 32'(exp_rx.size()), 32'd0);
    chk({name, "_miso_left"}, 32'(exp_miso.size()), 32'd0);
    chk({name, "_underruns"}, 32'(urun_cnt - u0), 32'(exp_urun));
    exp_rx.delete();
    exp_miso.delete();
    u0 = urun_cnt;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected end of test sequence");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge wb_clk);
    chk("reset_state", 32'({spi_miso_o, spi_miso_oe_o, tx_ready_o, rx_valid_o, tx_underrun_o, busy_o, rx_data_o}),
        32'({1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));
    wb_rst_n = 1'b1;
    repeat (10) @(negedge wb_clk);
    u0 = urun_cnt;

    // single byte with queued tx
    tx_q.push_back(8'hA5);
    feed_words();
    chk("hold_full", 32'(tx_ready_o), 32'd0);
    exp_miso.push_back(8'hA5);
    exp_rx.push_back(8'h3C);
    spi_frame({8'h3C, 16'h0000}, 8);
    chk("ready_after", 32'(tx_ready_o), 32'd1);
    end_test("t1", 0);

    // nothing queued: default word and one underrun
    exp_miso.push_back(8'hFF);
    exp_rx.push_back(8'h81);
    spi_frame({8'h81, 16'h0000}, 8);
    end_test("t2", 1);

    // three-byte frame fed on tx_ready
    tx_q.push_back(8'h11); tx_q.push_back(8'h22); tx_q.push_back(8'h33);
    exp_miso.push_back(8'h11); exp_miso.push_back(8'h22); exp_miso.push_back(8'h33);
    exp_rx.push_back(8'h01); exp_rx.push_back(8'h02); exp_rx.push_back(8'h03);
    fork
      spi_frame({8'h01, 8'h02, 8'h03}, 24);
      feed_words();
    join
    end_test("t3", 0);

    // abort after 5 bits, then a clean frame
    spi_frame({8'hF0, 16'h0000}, 5);
    chk("abort_busy", 32'(busy_o), 32'd0);
    end_test("t4a", 1);
    tx_q.push_back(8'h5A);
    feed_words();
    exp_miso.push_back(8'h5A);
    exp_rx.push_back(8'h69);
    spi_frame({8'h69, 16'h0000}, 8);
    end_test("t4b", 0);

    // reset pulse in the middle of bit 3
    miso_en = 1'b0;
    fork
      spi_frame({8'h96, 16'h0000}, 8);
      begin
        repeat (32) @(negedge wb_clk);
        chk("busy_mid", 32'(busy_o), 32'd1);
        wb_rst_n = 1'b0;
        @(negedge wb_clk);
        wb_rst_n = 1'b1;
        chk("reset_mid", 32'({spi_miso_o, spi_miso_oe_o, tx_ready_o, rx_valid_o, tx_underrun_o, busy_o, rx_data_o}),
            32'({1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));
      end
    join
    miso_en = 1'b1;
    end_test("t5", 1);

    // tx_valid lands on the load edge with the register empty
    exp_miso.push_back(8'hFF); exp_miso.push_back(8'hE7);
    exp_rx.push_back(8'h12); exp_rx.push_back(8'h34);
    fork
      spi_frame({8'h12, 8'h34, 8'h00}, 16);
      begin
        @(negedge spi_ss_n_i);
        repeat (3) @(negedge wb_clk);
        chk("coll_ready", 32'(tx_ready_o), 32'd1);
        tx_data_i  = 8'hE7;
        tx_valid_i = 1'b1;
        @(negedge wb_clk);
        tx_valid_i = 1'b0;
        chk("coll_queued", 32'(tx_ready_o), 32'd0);
      end
    join
    end_test("t6", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_if.md
# spi_slave_if

SPI responder (mode 0, MSB first) that lets an external SPI master, such as another board's SPI controller or a debug dongle, exchange bytes with the SoC. It is the target-side counterpart of the spi0/spi1/spi2 master ports on the DE0 Nano top level. All SPI pins are oversampled in the system clock domain. A byte-wide valid/ready transmit port and a valid-pulse receive port face the core-side logic.

## Interface
- DATA_WIDTH, 8: bits per SPI word.
- SYNC_STAGES, 2: synchroniser flops on sck, ss_n and mosi (minimum 2).
- DEFAULT_TX, 8'hFF: word shifted out when no transmit data is pending.

Ports:
- wb_clk  in  1  system clock; all logic on the rising edge.
- wb_rst_n  in  1  synchronous active-low reset.
- spi_sck_i  in  1  SPI clock from master, asynchronous.
- spi_ss_n_i  in  1  slave select from master, active-low, asynchronous.
- spi_mosi_i  in  1  master-out data, asynchronous.
- spi_miso_o  out  1  slave-out data.
- spi_miso_oe_o  out  1  miso output enable; tristating is done at top level.
- tx_data_i  in  DATA_WIDTH  next word to send.
- tx_valid_i  in  1  tx_data_i is valid.
- tx_ready_o  out  1  holding register is empty.
- rx_data_o  out  DATA_WIDTH  last received word; held until the next word.
- rx_valid_o  out  1  one-cycle pulse when a complete word has been received.
- tx_underrun_o  out  1  one-cycle pulse when DEFAULT_TX is loaded because no data was pending.
- busy_o  out  1  synchronised select is active.

## Operation
- Synchronisers feed sck, ss_n and mosi through SYNC_STAGES flops. Edge detect compares the last stage against one further delayed flop.
- Transmit holding register, one entry:
  - tx_ready_o is 1 when empty.
  - tx_valid_i && tx_ready_o captures the word; tx_ready_o goes 0 the next cycle.
  - The entry frees on the cycle after it is moved into the shift register.
- FSM states IDLE, LOAD, SHIFT:
  - IDLE: miso_oe=0. A falling edge on synced ss_n goes to LOAD.
  - LOAD (one cycle): the tx shift register takes the holding word, or DEFAULT_TX with a tx_underrun_o pulse. bit_cnt=0. Miso drives the shift register MSB. Next state is SHIFT.
  - SHIFT, synced sck rising edge: shift mosi into the rx register and increment bit_cnt. When bit_cnt == DATA_WIDTH-1, update rx_data_o, pulse rx_valid_o and wrap bit_cnt to 0.
  - SHIFT, synced sck falling edge:
    - If bit_cnt != 0, shift tx left and present the next bit.
    - If bit_cnt == 0 and at least one word has completed in this frame, reload from holding/DEFAULT_TX, exactly as in LOAD.
  - Any state, synced ss_n high: go to IDLE.
    - The partial rx word is discarded, with no rx_valid.
    - The partially sent tx word is dropped and not re-queued.
    - The holding register is untouched.
- Simultaneous events:
  - Capture into an empty holding register in the same cycle as a load: the load sees an empty register (DEFAULT_TX plus underrun), and the new word stays queued.
  - rx has no backpressure. An un-consumed rx_data_o is simply overwritten.
- busy_o = SHIFT or LOAD.

## Timing
- Required: sck high and low times ≥ (SYNC_STAGES+2) wb_clk periods each. ss_n falling edge to first sck rising edge ≥ SYNC_STAGES+3 wb_clk periods.
- Miso latency:
  - First bit is valid SYNC_STAGES+2 cycles after the ss_n fall at the pin.
  - Later bits are valid SYNC_STAGES+2 cycles after each sck fall.
- rx_valid_o rises SYNC_STAGES+2 cycles after the pin-level rising edge of the last bit.
- Reset values:
  - spi_miso_o=0, spi_miso_oe_o=0, tx_ready_o=1.
  - rx_data_o=0, rx_valid_o=0, tx_underrun_o=0, busy_o=0.
  - FSM = IDLE, bit_cnt=0, holding register empty.
  - Synchroniser flops reset to idle levels: sck=0, ss_n=1.
- Reset mid-frame returns the block to the reset state immediately. The master's current frame is ignored until ss_n is seen deasserted and then reasserted.

## Structure
- Shared package spi_pkg holds:
  - the state enum (IDLE/LOAD/SHIFT);
  - SPI mode constants (CPOL=0, CPHA=0);
  - the default sync depth.
  - The spi0–2 masters reuse it.
- One natural sub-module, spi_sync_edge: N-stage synchroniser with registered rise/fall strobes, instantiated for sck and ss_n. Mosi uses the synchroniser only.

## Test plan
- Queue tx 8'hA5, master sends 8'h3C with wb_clk/8 sck -> master reads 8'hA5; rx_data_o=8'h3C with one rx_valid pulse; tx_ready_o returns to 1.
- No tx queued, master sends 8'h81 -> master reads 8'hFF; tx_underrun_o pulses once at select; rx_data_o=8'h81.
- 3-byte frame with tx 8'h11, 8'h22, 8'h33 supplied one at a time on tx_ready_o; master sends 8'h01, 8'h02, 8'h03:
  - master reads 11 22 33;
  - three rx_valid pulses with 01, 02, 03;
  - no underrun.
- Deassert ss_n after 5 bits of 8'hF0 -> no rx_valid; busy_o=0; next frame starts at bit 7 with a fresh load.
- wb_rst_n low mid-byte for 1 cycle -> all outputs at reset values the next cycle; the remainder of that frame produces no rx_valid.
- tx_valid asserted in the same cycle as LOAD with the holding register empty -> DEFAULT_TX is sent with an underrun pulse; the queued word goes out in the next word.
